// File: rtl/dmem_responder.sv
// Purpose: word-organised scratchpad at the far end of the MEM-stage dmem interface; answers each request with a one-cycle dmem_resp pulse.
// Latency: LATENCY cycles from request to dmem_resp (LATENCY..LATENCY+7 when DMEM_RAND_LAT_EN is defined).
// Backpressure: one request outstanding; requests are sampled only while idle, and busy stays high through the dmem_resp cycle.
module dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1ECE_B000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err,
    output logic        busy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    // Wide enough for LATENCY up to 15 plus a random extension of up to 7.
    localparam int unsigned CNT_W = 5;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_rdata;
    logic             pend_err;

    // Scratchpad: deliberately not reset, so contents survive rst_n.
    logic [31:0]      mem [DEPTH];

    logic [31:0]      offset;
    logic             in_range;
    logic             is_req;
    logic             bad_req;
    logic             accept;
    logic             mem_we;
    logic [AW-1:0]    idx;
    logic [31:0]      lane_mask;
    logic [31:0]      rd_word;
    logic [CNT_W-1:0] lat_eff;

    // Address decode: unsigned offset from the window base; the >= test stops
    // addresses below the base from wrapping into range.
    assign offset   = dmem_addr - BASE_ADDR;
    assign in_range = (dmem_addr >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[AW+1:2];

    // A request is any nonzero mask; both masks set at once is malformed.
    assign is_req   = (|dmem_rmask) || (|dmem_wmask);
    assign bad_req  = !in_range || ((|dmem_rmask) && (|dmem_wmask));
    assign accept   = (state == S_IDLE) && is_req;

    // rst_n gate keeps a request held during reset from writing the array.
    assign mem_we   = accept && !bad_req && (|dmem_wmask) && rst_n;

    // Unselected read lanes are returned as zero; errors return all zero.
    assign lane_mask = {{8{dmem_rmask[3]}}, {8{dmem_rmask[2]}},
                        {8{dmem_rmask[1]}}, {8{dmem_rmask[0]}}};
    assign rd_word   = bad_req ? 32'h0 : (mem[idx] & lane_mask);

`ifdef DMEM_RAND_LAT_EN
    logic [15:0] lfsr;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running to jitter response latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign lat_eff = CNT_W'(LATENCY) + {2'b00, lfsr[2:0]};
`else
    assign lat_eff = CNT_W'(LATENCY);
`endif

    // Byte-lane write, committed at the acceptance edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wmask[b]) begin
                    mem[idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request FSM: capture response at acceptance, count down, emit a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
            dmem_rdata <= '0;
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy <= 1'b1;
                        cnt  <= lat_eff - CNT_W'(1);
                        if (lat_eff == CNT_W'(1)) begin
                            state      <= S_RESP;
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= rd_word;
                            dmem_err   <= bad_req;
                        end else begin
                            state      <= S_WAIT;
                            pend_rdata <= rd_word;
                            pend_err   <= bad_req;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state      <= S_RESP;
                        cnt        <= '0;
                        dmem_resp  <= 1'b1;
                        dmem_rdata <= pend_rdata;
                        dmem_err   <= pend_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    // Inputs seen in this cycle are ignored; next acceptance is one cycle later.
                    state      <= S_IDLE;
                    dmem_resp  <= 1'b0;
                    dmem_rdata <= '0;
                    dmem_err   <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
